// File: rtl/inertial_fusion_mc.sv
// ----------------------------------------------------------------------------
// inertial_fusion_mc
// Per-axis complementary filter. Each axis integrates the offset-corrected gyro
// rate and is pulled towards the accelerometer-derived angle by a fixed step
// per sample. A calibration mode averages 2^CAL_LOG2 samples to learn new
// gyro and accel offsets.
//
// Build option: define INERTIAL_SAT_EN to clamp integrator overflow and
// report it on sat. Without it the integrators wrap and sat reads 0.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   vld        one-cycle strobe, new rt/acc samples present
//   rt         NUM_CH x signed 16-bit gyro rates, channel k at [16k+15:16k]
//   acc        NUM_CH x signed 16-bit accel readings, same packing
//   cal_start  request offset calibration
//   cal_busy   high while calibrating
//   cal_done   one-cycle pulse when calibration completes
//   ang        NUM_CH x signed 16-bit fused angles (integrator top 16 bits)
//   ang_vld    one-cycle strobe, ang was updated
//   sat        sticky per-channel saturation flags
//
// state | meaning
// RUN   | integrate on every vld, accept cal_start
// CAL   | accumulate offset sums, integrators hold
// ----------------------------------------------------------------------------
module inertial_fusion_mc #(
   parameter int NUM_CH     = 2,
   parameter int RT_OFFSET  = 80,
   parameter int ACC_OFFSET = 160,
   parameter int ACC_GAIN   = 327,
   parameter int FUSE_STEP  = 1024,
   parameter int INT_W      = 27,
   parameter int CAL_LOG2   = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   vld,
   input  logic [NUM_CH*16-1:0]   rt,
   input  logic [NUM_CH*16-1:0]   acc,
   input  logic                   cal_start,
   output logic                   cal_busy,
   output logic                   cal_done,
   output logic [NUM_CH*16-1:0]   ang,
   output logic                   ang_vld,
   output logic [NUM_CH-1:0]      sat
);

   localparam int AW    = INT_W + 2;
   localparam int SUM_W = 16 + CAL_LOG2;

   localparam logic signed [AW-1:0] STEP_P  = AW'(FUSE_STEP);
   localparam logic signed [AW-1:0] STEP_N  = AW'(-FUSE_STEP);
   localparam logic signed [AW-1:0] INT_MAX = AW'((longint'(1) <<< (INT_W - 1)) - 1);
   localparam logic signed [AW-1:0] INT_MIN = AW'(-(longint'(1) <<< (INT_W - 1)));

   typedef enum logic {RUN, CAL} state_t;

   state_t                     state;
   logic [CAL_LOG2-1:0]        cnt;
   logic signed [INT_W-1:0]    int_q   [NUM_CH];
   logic signed [15:0]         rt_off  [NUM_CH];
   logic signed [15:0]         acc_off [NUM_CH];
   logic signed [SUM_W-1:0]    rt_sum  [NUM_CH];
   logic signed [SUM_W-1:0]    acc_sum [NUM_CH];

   logic [NUM_CH*INT_W-1:0]    int_nxt;
   logic [NUM_CH*SUM_W-1:0]    rt_sum_add;
   logic [NUM_CH*SUM_W-1:0]    acc_sum_add;
   logic [NUM_CH-1:0]          ovf;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      logic signed [15:0]    rt_k, acc_k, ang_k;
      logic signed [16:0]    rc, d;
      logic signed [31:0]    prod, a, ang_ext;
      logic signed [AW-1:0]  sum;

      assign rt_k    = rt[16*k +: 16];
      assign acc_k   = acc[16*k +: 16];
      assign ang_k   = int_q[k][INT_W-1 -: 16];
      assign rc      = 17'(rt_k) - 17'(rt_off[k]);
      assign d       = 17'(acc_k) - 17'(acc_off[k]);
      assign prod    = 32'(d) * 32'(ACC_GAIN);
      assign a       = prod >>> 12;
      assign ang_ext = 32'(ang_k);
      // Ties (a == ang) pull downwards.
      assign sum     = AW'(int_q[k]) - AW'(rc) + ((a > ang_ext) ? STEP_P : STEP_N);

`ifdef INERTIAL_SAT_EN
      assign ovf[k] = (sum > INT_MAX) || (sum < INT_MIN);
      assign int_nxt[k*INT_W +: INT_W] = (sum > INT_MAX) ? INT_W'(INT_MAX) :
                                         (sum < INT_MIN) ? INT_W'(INT_MIN) :
                                                           INT_W'(sum);
`else
      assign ovf[k] = 1'b0;
      assign int_nxt[k*INT_W +: INT_W] = INT_W'(sum);
`endif

      assign rt_sum_add[k*SUM_W +: SUM_W]  = rt_sum[k] + SUM_W'(rt_k);
      assign acc_sum_add[k*SUM_W +: SUM_W] = acc_sum[k] + SUM_W'(acc_k);
      assign ang[16*k +: 16] = ang_k;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RUN;
         cnt      <= '0;
         cal_busy <= 1'b0;
         cal_done <= 1'b0;
         ang_vld  <= 1'b0;
         sat      <= '0;
         for (int k = 0; k < NUM_CH; k++) begin
            int_q[k]   <= '0;
            rt_off[k]  <= 16'(RT_OFFSET);
            acc_off[k] <= 16'(ACC_OFFSET);
            rt_sum[k]  <= '0;
            acc_sum[k] <= '0;
         end
      end else begin
         ang_vld  <= 1'b0;
         cal_done <= 1'b0;
         case (state)
            RUN: begin
               if (cal_start) begin
                  state    <= CAL;
                  cal_busy <= 1'b1;
                  cnt      <= '0;
                  sat      <= '0;
                  for (int k = 0; k < NUM_CH; k++) begin
                     rt_sum[k]  <= '0;
                     acc_sum[k] <= '0;
                  end
               end else if (vld) begin
                  ang_vld <= 1'b1;
                  sat     <= sat | ovf;
                  for (int k = 0; k < NUM_CH; k++)
                     int_q[k] <= int_nxt[k*INT_W +: INT_W];
               end
            end
            CAL: begin
               if (vld) begin
                  cnt <= cnt + 1'b1;
                  for (int k = 0; k < NUM_CH; k++) begin
                     rt_sum[k]  <= rt_sum_add[k*SUM_W +: SUM_W];
                     acc_sum[k] <= acc_sum_add[k*SUM_W +: SUM_W];
                  end
                  if (cnt == '1) begin
                     state    <= RUN;
                     cal_busy <= 1'b0;
                     cal_done <= 1'b1;
                     // Top 16 bits of the final sum = arithmetic shift by CAL_LOG2.
                     for (int k = 0; k < NUM_CH; k++) begin
                        rt_off[k]  <= rt_sum_add[k*SUM_W + CAL_LOG2 +: 16];
                        acc_off[k] <= acc_sum_add[k*SUM_W + CAL_LOG2 +: 16];
                        int_q[k]   <= '0;
                     end
                  end
               end
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: doc/inertial_fusion_mc.md
INERTIAL_FUSION_MC -- requirements
Module: inertial_fusion_mc

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning): NUM_CH, 2, number of independent axes.
REQ-002 RT_OFFSET, 80, reset-time gyro rate offset for every channel.
REQ-003 ACC_OFFSET, 160, reset-time accelerometer offset for every channel.
REQ-004 ACC_GAIN, 327, accel-to-angle multiplier.
REQ-005 FUSE_STEP, 1024, fusion correction per valid sample.
REQ-006 INT_W, 27, integrator width; output angle is bits [INT_W-1 -: 16].
REQ-007 CAL_LOG2, 8, log2 of calibration sample count.
REQ-008 The module SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- vld  in  1  one-cycle strobe; new sensor samples are present.
- rt  in  NUM_CH*16  signed gyro rates; channel k at [16k+15:16k].
- acc  in  NUM_CH*16  signed accel readings; same packing.
- cal_start  in  1  request offset calibration.
- cal_busy  out  1  high while calibrating.
- cal_done  out  1  one-cycle pulse when calibration completes.
- ang  out  NUM_CH*16  signed fused angles; same packing.
- ang_vld  out  1  one-cycle strobe; ang was updated.
- sat  out  NUM_CH  sticky per-channel saturation flags.

Function
REQ-009 The FSM SHALL have two states, RUN and CAL; after reset it SHALL be in RUN.
REQ-010 In RUN, a vld with cal_start low SHALL update every channel k, all in the same cycle:
- rc = rt_k - rt_off_k
- a = ((acc_k - acc_off_k) * ACC_GAIN) >>> 12, sign-extended
- int_k <= int_k - rc + FUSE_STEP when a > ang_k; otherwise int_k <= int_k - rc - FUSE_STEP.
REQ-011 When a == ang_k, the module SHALL apply -FUSE_STEP.
REQ-012 ang_vld SHALL pulse exactly one cycle after each RUN-state vld, and ang SHALL reflect the updated integrators in that cycle.
REQ-013 The module SHALL perform the arithmetic at INT_W+2 bits before the write-back.
REQ-014 cal_start sampled in RUN SHALL cause the following:
- go to CAL next cycle;
- clear the sample counter and the sums;
- clear sat;
- suppress integration for a vld in the same cycle.
REQ-015 In CAL, each vld SHALL add rt_k and acc_k into per-channel signed sums of 16+CAL_LOG2 bits and increment the counter.
REQ-016 ang_vld SHALL stay low in CAL, and the integrators SHALL hold.
REQ-017 On the 2^CAL_LOG2-th vld in CAL, the module SHALL do the following on the next edge:
- rt_off_k = rt_sum_k >>> CAL_LOG2 and acc_off_k = acc_sum_k >>> CAL_LOG2 (arithmetic shift, truncate);
- clear all int_k;
- pulse cal_done for one cycle;
- return to RUN.
REQ-018 cal_start in CAL SHALL be ignored; the count SHALL not restart.
REQ-019 cal_busy SHALL be high exactly while the state is CAL.

Reset
REQ-020 rst high at a clk edge SHALL force the following:
- state RUN, counter 0, sums 0;
- int_k 0, so ang = 0;
- ang_vld, cal_done and cal_busy 0, sat 0;
- rt_off_k = RT_OFFSET and acc_off_k = ACC_OFFSET.
REQ-021 rst SHALL take priority over vld and cal_start; reset during CAL SHALL abort calibration and discard the partial sums.

Configuration
REQ-022 Macro INERTIAL_SAT_EN defined: a result outside the signed INT_W range SHALL clamp to the maximum or minimum value and set sat[k], which stays set until rst or cal_start.
REQ-023 Macro INERTIAL_SAT_EN undefined: results SHALL wrap modulo 2^INT_W, and sat SHALL be tied to 0.

Verification
REQ-024 The bench SHALL cover these scenarios:
- Reset, then one vld with rt=80, acc=160 on all channels -> ang_vld one cycle later; int = -1024; ang = 16'hFFFF.
- RUN, ch0 rt=-944, acc=160, int=0 (ang=0), so a=0 == ang -> rc=-1024 and -1024 step; int0 stays 0; ch1 with rt=80 gives int1 = -1024.
- cal_start, then 256 vld with rt=100, acc=-40 -> cal_busy for the whole window; no ang_vld; cal_done one cycle after the 256th vld; offsets 100/-40; ang=0; then vld with rt=100, acc=-40 gives int=-1024.
- cal_start asserted again at sample 100 of CAL -> ignored; cal_done still after the 256th vld.
- rst asserted at CAL sample 50 -> state RUN; offsets 80/160; next vld integrates normally.
- INERTIAL_SAT_EN defined, rt=-32768 repeated until overflow -> int clamps at 2^26-1 and sat[k]=1; undefined -> int wraps negative and sat=0.
